// File: rtl/connector_pkg.sv
// connector_pkg: shared commit-path types, the buffered commit entry and the scheduler state.
// XLEN is the PC width; fu_op and cf_t describe the retired instruction.
package connector_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
    OP_JALR, OP_MUL, OP_DIV, OP_CSR, OP_FENCE, OP_NOP
  } fu_op;
  typedef enum logic [2:0] {CF_NONE, CF_BRANCH, CF_JUMP, CF_CALL, CF_RET, CF_IJUMP} cf_t;
  localparam int OP_W = $bits(fu_op);
  localparam int CF_W = $bits(cf_t);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    fu_op            op;
    cf_t             cf;
    logic            taken;
    logic            exc;
  } commit_entry_t;
  typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} sched_state_t;
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: multi-write, single-read ring buffer for commit entries.
// Ports: clk_i/rst_i (async high), clr_i empties the buffer, wr_en_i/wr_data_i per-port
// writes packed in ascending port order, rd_en_i pops the head, rd_data_o is the head slot,
// count_o is the occupancy. The caller guarantees no overflow and no pop when empty.
module commit_fifo
  import connector_pkg::*;
#(
  parameter int NRET = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic [NRET-1:0]            wr_en_i,
  input  commit_entry_t [NRET-1:0]   wr_data_i,
  input  logic                       rd_en_i,
  output commit_entry_t              rd_data_o,
  output logic [AW:0]                count_o
);
  commit_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d, n_wr;
  logic [NRET-1:0][AW-1:0] slot;
  // Each valid port lands at the write pointer plus the number of valid ports below it,
  // so invalid ports leave no holes.
  always_comb begin
    slot = '0;
    n_wr = '0;
    for (int i = 0; i < NRET; i++) begin
      slot[i] = wr_ptr_q + n_wr[AW-1:0];
      n_wr += (AW+1)'(wr_en_i[i]);
    end
  end
  always_comb begin
    wr_ptr_d = clr_i ? '0 : wr_ptr_q + n_wr[AW-1:0];
    rd_ptr_d = clr_i ? '0 : rd_ptr_q + AW'(rd_en_i);
    count_d  = clr_i ? '0 : count_q + n_wr - (AW+1)'(rd_en_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++)
      if (wr_en_i[i] && !clr_i) mem_q[slot[i]] <= wr_data_i[i];
  end
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
endmodule

// File: rtl/commit_scheduler.sv
// commit_scheduler: serializes up to NRET commits per cycle into a one-per-cycle stream.
// Ports: commit_*_i per-port commit bundle (port 0 oldest), commit_ready_o upstream accept,
// flush_i discards everything, out_*_o head entry with out_valid_o/out_ready_i handshake,
// count_o buffer occupancy. An exception pop holds intake until the buffer drains.
module commit_scheduler
  import connector_pkg::*;
#(
  parameter int NRET = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NRET-1:0]            commit_valid_i,
  input  logic [NRET-1:0][XLEN-1:0]  commit_pc_i,
  input  logic [NRET-1:0][OP_W-1:0]  commit_op_i,
  input  logic [NRET-1:0][CF_W-1:0]  commit_cf_i,
  input  logic [NRET-1:0]            commit_taken_i,
  input  logic [NRET-1:0]            commit_exc_i,
  output logic                       commit_ready_o,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [OP_W-1:0]            out_op_o,
  output logic [CF_W-1:0]            out_cf_o,
  output logic                       out_taken_o,
  output logic                       out_exc_o,
  output logic [AW:0]                count_o
);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH - NRET);
  sched_state_t state_q, state_d;
  commit_entry_t [NRET-1:0] wr_data;
  commit_entry_t head;
  logic [NRET-1:0] push_v;
  logic pop;
  // Ready looks only at registered state so upstream never depends on this cycle's pop.
  assign commit_ready_o = !rst_i && state_q == S_RUN && count_o <= CAP;
  assign out_valid_o    = count_o != '0 && state_q != S_FLUSH;
  assign push_v         = commit_valid_i & {NRET{commit_ready_o && !flush_i}};
  assign pop            = out_valid_o && out_ready_i && !flush_i;
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NRET; i++)
      wr_data[i] = '{pc: commit_pc_i[i], op: fu_op'(commit_op_i[i]), cf: cf_t'(commit_cf_i[i]),
                     taken: commit_taken_i[i], exc: commit_exc_i[i]};
  end
  // HOLD takes no pushes, so the buffer is empty next cycle exactly when it is empty now
  // or its last entry pops now.
  always_comb begin
    state_d = flush_i            ? S_FLUSH :
              state_q == S_FLUSH ? S_RUN :
              state_q == S_RUN   ? (pop && head.exc ? S_HOLD : S_RUN) :
              (count_o == '0 || (count_o == (AW+1)'(1) && pop)) ? S_RUN : S_HOLD;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_RUN;
    else       state_q <= state_d;
  end
  commit_fifo #(.NRET(NRET), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .wr_en_i   (push_v),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count_o)
  );
  assign out_pc_o    = head.pc;
  assign out_op_o    = head.op;
  assign out_cf_o    = head.cf;
  assign out_taken_o = head.taken;
  assign out_exc_o   = head.exc;
endmodule

// File: tb/tb_commit_scheduler.sv
// tb_commit_scheduler: directed vectors, wrap-around ordering, reset and random traffic vs a queue model.
module tb_commit_scheduler;
  localparam int NRET = 2;
  localparam int DEPTH = 4;
  typedef struct packed {logic [31:0] pc; logic [3:0] op; logic [2:0] cf; logic tk; logic ex;} ent_t;
  typedef struct {logic [1:0] v; ent_t e0; ent_t e1; logic ordy; logic fl;} stim_t;
  typedef struct {stim_t s; int cnt; logic vld; logic rdy; logic [31:0] pc;} vec_t;
  logic clk = 0, rst = 1;
  logic [1:0] cv = '0, ctk = '0, cex = '0;
  logic [1:0][31:0] cpc = '0;
  logic [1:0][3:0] cop = '0;
  logic [1:0][2:0] ccf = '0;
  logic crdy, fl = 0, ovld, ordy = 0, otk, oex;
  logic [31:0] opc;
  logic [3:0] oop;
  logic [2:0] ocf, cnt;
  int checks = 0, errors = 0;
  ent_t mq[$];
  int mmode = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  commit_scheduler #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_pc_i(cpc), .commit_op_i(cop),
    .commit_cf_i(ccf), .commit_taken_i(ctk), .commit_exc_i(cex), .commit_ready_o(crdy),
    .flush_i(fl), .out_valid_o(ovld), .out_ready_i(ordy), .out_pc_o(opc), .out_op_o(oop),
    .out_cf_o(ocf), .out_taken_o(otk), .out_exc_o(oex), .count_o(cnt)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic ent_t me(logic [31:0] pc, logic ex);
    return '{pc: pc, op: pc[5:2], cf: pc[4:2], tk: pc[3], ex: ex};
  endfunction
  function automatic stim_t ms(logic [1:0] v, logic [31:0] p0, logic [31:0] p1, logic x0, logic o, logic f);
    stim_t s;
    s.v = v; s.e0 = me(p0, x0); s.e1 = me(p1, 1'b0); s.ordy = o; s.fl = f;
    return s;
  endfunction
  function automatic vec_t mk(logic [1:0] v, logic [31:0] p0, logic [31:0] p1, logic x0, logic o,
                              logic f, int c, logic vl, logic rd, logic [31:0] pc);
    vec_t r;
    r.s = ms(v, p0, p1, x0, o, f); r.cnt = c; r.vld = vl; r.rdy = rd; r.pc = pc;
    return r;
  endfunction
  function automatic bit m_rdy();
    return mmode == 0 && mq.size() <= DEPTH - NRET;
  endfunction
  function automatic bit m_vld();
    return mq.size() > 0 && mmode != 2;
  endfunction
  task automatic mcheck();
    chk("model.count", 32'(cnt), 32'(mq.size()));
    chk("model.ready", 32'(crdy), 32'(m_rdy()));
    chk("model.valid", 32'(ovld), 32'(m_vld()));
    if (m_vld()) begin
      chk("model.pc", opc, mq[0].pc);
      chk("model.fields", 32'({oop, ocf, otk, oex}), 32'({mq[0].op, mq[0].cf, mq[0].tk, mq[0].ex}));
    end
  endtask
  task automatic mupdate(stim_t s);
    bit r, p, hx;
    r = m_rdy();
    if (s.fl) begin
      mq.delete();
      mmode = 2;
    end else begin
      p = m_vld() && s.ordy;
      hx = p && mq[0].ex;
      if (p) void'(mq.pop_front());
      if (r && s.v[0]) mq.push_back(s.e0);
      if (r && s.v[1]) mq.push_back(s.e1);
      mmode = mmode == 2 ? 0 : mmode == 0 ? (hx ? 1 : 0) : (mq.size() == 0 ? 0 : 1);
    end
  endtask
  task automatic tick(stim_t s);
    cv = s.v; fl = s.fl; ordy = s.ordy;
    cpc[0] = s.e0.pc; cop[0] = s.e0.op; ccf[0] = s.e0.cf; ctk[0] = s.e0.tk; cex[0] = s.e0.ex;
    cpc[1] = s.e1.pc; cop[1] = s.e1.op; ccf[1] = s.e1.cf; ctk[1] = s.e1.tk; cex[1] = s.e1.ex;
    @(posedge clk);
    mupdate(s);
    @(negedge clk);
    mcheck();
  endtask
  initial begin
    stim_t s;
    int pushed, got;
    tbl.push_back(mk(2'b11, 32'h100, 32'h104, 0, 1, 0, 2, 1, 1, 32'h100));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 1, 1, 32'h104));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b10, 0, 32'h200, 0, 0, 0, 1, 1, 1, 32'h200));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b11, 32'h110, 32'h114, 0, 0, 0, 2, 1, 1, 32'h110));
    tbl.push_back(mk(2'b11, 32'h118, 32'h11c, 0, 0, 0, 4, 1, 0, 32'h110));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 4, 1, 0, 32'h110));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 3, 1, 0, 32'h114));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 2, 1, 1, 32'h118));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 1, 1, 32'h11c));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b11, 32'h300, 32'h304, 1, 0, 0, 2, 1, 1, 32'h300));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 1, 0, 32'h304));
    tbl.push_back(mk(2'b11, 32'h400, 32'h404, 0, 0, 0, 1, 1, 0, 32'h304));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b11, 32'h500, 32'h504, 0, 0, 0, 2, 1, 1, 32'h500));
    tbl.push_back(mk(2'b01, 32'h508, 0, 0, 0, 0, 3, 1, 0, 32'h500));
    tbl.push_back(mk(2'b11, 32'h50c, 32'h510, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2'b11, 32'h600, 32'h604, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b11, 32'h700, 32'h704, 0, 1, 0, 2, 1, 1, 32'h700));
    tbl.push_back(mk(2'b11, 32'h800, 32'h804, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2'b01, 32'h900, 0, 1, 0, 0, 1, 1, 1, 32'h900));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    #3;
    chk("reset.ready", 32'(crdy), 0);
    chk("reset.valid", 32'(ovld), 0);
    chk("reset.count", 32'(cnt), 0);
    @(negedge clk);
    rst = 0;
    #1;
    mcheck();
    foreach (tbl[i]) begin
      tick(tbl[i].s);
      chk($sformatf("vec%0d.count", i), 32'(cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.valid", i), 32'(ovld), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.ready", i), 32'(crdy), 32'(tbl[i].rdy));
      if (tbl[i].vld) chk($sformatf("vec%0d.pc", i), opc, tbl[i].pc);
    end
    pushed = 0;
    got = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      s = ms(2'b00, 0, 0, 0, 1, 0);
      if (pushed < 10 && m_rdy()) begin
        s = ms(2'b11, 32'h1000 + 32'(pushed * 8), 32'h1004 + 32'(pushed * 8), 0, 1, 0);
        pushed++;
      end
      tick(s);
      if (ovld) begin
        chk("wrap.order", opc, 32'h1000 + 32'(got * 4));
        got++;
      end
    end
    chk("wrap.total", 32'(got), 20);
    for (int c = 0; c < 400; c++) begin
      s = ms(2'($urandom), {$urandom_range(0, 65535), 2'b00}, {$urandom_range(0, 65535), 2'b00},
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      s.e1.ex = $urandom_range(0, 7) == 0;
      tick(s);
    end
    tick(ms(2'b00, 0, 0, 0, 0, 1));
    tick(ms(2'b11, 32'h40, 32'h44, 0, 0, 0));
    tick(ms(2'b11, 32'h48, 32'h4c, 0, 0, 0));
    #2;
    rst = 1;
    #1;
    chk("midreset.count", 32'(cnt), 0);
    chk("midreset.valid", 32'(ovld), 0);
    chk("midreset.ready", 32'(crdy), 0);
    mq.delete();
    mmode = 0;
    @(negedge clk);
    rst = 0;
    tick(ms(2'b11, 32'ha00, 32'ha04, 0, 0, 0));
    chk("postreset.count", 32'(cnt), 2);
    chk("postreset.pc", opc, 32'ha00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
